// File: rtl/systolic_pkg.sv
// ============================================================================
// Module   : systolic_pkg
// Purpose  : Shared state and phase encodings for the systolic array controllers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package systolic_pkg;

  // Result-drain FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    CLR   = 2'd3
  } drain_state_t;

  // Load/MAC controller phases, kept here so both controllers agree
  typedef enum logic [1:0] {
    LOAD = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } ctrl_phase_t;

endpackage : systolic_pkg

`default_nettype wire

// File: rtl/systolic_drain_if.sv
// ============================================================================
// Module   : systolic_drain_if
// Purpose  : Valid/ready result stream leaving the drain engine.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface systolic_drain_if #(
  parameter int OUT_W = 16
);
  logic [OUT_W-1:0] out_msg;
  logic             out_val;
  logic             out_rdy;

  modport master (
    output out_msg,
    output out_val,
    input  out_rdy
  );

  modport slave (
    input  out_msg,
    input  out_val,
    output out_rdy
  );
endinterface : systolic_drain_if

`default_nettype wire

// File: rtl/systolic_sat.sv
// ============================================================================
// Module   : systolic_sat
// Purpose  : Combinational ACC_W -> OUT_W narrowing; saturating when
//            SYSTOLIC_DRAIN_SAT_EN is defined, truncating otherwise.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module systolic_sat #(
  parameter int ACC_W = 32,
  parameter int OUT_W = 16
) (
  input  wire logic [ACC_W-1:0] i_acc,
  output logic      [OUT_W-1:0] o_msg
);

  generate
    if (OUT_W == ACC_W) begin : g_pass
      assign o_msg = i_acc;
    end else begin : g_narrow
`ifdef SYSTOLIC_DRAIN_SAT_EN
      // Value fits when every bit from OUT_W-1 upward equals the sign
      logic [ACC_W-OUT_W:0] w_hi;
      assign w_hi = i_acc[ACC_W-1:OUT_W-1];

      always_comb begin
        o_msg = i_acc[OUT_W-1:0];
        if (!((&w_hi) || (~|w_hi))) begin
          if (i_acc[ACC_W-1]) o_msg = {1'b1, {(OUT_W-1){1'b0}}};
          else                o_msg = {1'b0, {(OUT_W-1){1'b1}}};
        end
      end
`else
      logic w_unused_hi;
      assign w_unused_hi = ^i_acc[ACC_W-1:OUT_W];
      assign o_msg       = i_acc[OUT_W-1:0];
`endif
    end
  endgenerate

endmodule : systolic_sat

`default_nettype wire

// File: rtl/systolic_drain.sv
// ============================================================================
// Module   : systolic_drain
// Purpose  : Reads the PE accumulators row by row and streams them out in
//            row-major order, then clears the array. Option macro:
//            SYSTOLIC_DRAIN_SAT_EN (saturating narrowing).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module systolic_drain
  import systolic_pkg::*;
#(
  parameter int size  = 4,
  parameter int ACC_W = 32,
  parameter int OUT_W = 16
) (
  input  wire logic                       clk,
  input  wire logic                       rst_n,
  input  wire logic                       start,
  output logic      [$clog2(size)-1:0]    row_sel,
  input  wire logic [size*ACC_W-1:0]      row_data,
  output logic                            acc_clr,
  output logic                            busy,
  output logic                            done,
  output logic      [1:0]                 trace_state,
  systolic_drain_if.master                out_if
);

  localparam int                      c_IDX_W = $clog2(size);
  localparam logic [c_IDX_W-1:0]      c_LAST  = c_IDX_W'(size - 1);
  localparam logic [c_IDX_W-1:0]      c_ONE   = c_IDX_W'(1);

  drain_state_t          r_state;
  drain_state_t          w_state_next;
  logic [c_IDX_W-1:0]    r_row;
  logic [c_IDX_W-1:0]    r_col;
  logic [ACC_W-1:0]      r_buf [size];
  logic                  w_xfer;
  logic [OUT_W-1:0]      w_msg;

  // out_val comes from state alone, so the transfer qualifier is safe here
  assign w_xfer = (r_state == SEND) && out_if.out_rdy;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next   = r_state;
    out_if.out_val = 1'b0;
    acc_clr        = 1'b0;
    done           = 1'b0;
    busy           = 1'b1;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (start) w_state_next = FETCH;
      end
      FETCH: w_state_next = SEND;
      SEND: begin
        out_if.out_val = 1'b1;
        if (w_xfer && (r_col == c_LAST))
          w_state_next = (r_row == c_LAST) ? CLR : FETCH;
      end
      CLR: begin
        acc_clr      = 1'b1;
        done         = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Counters wrap to zero on the final transfer, so CLR already sees (0,0)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_row <= '0;
      r_col <= '0;
      for (int c = 0; c < size; c++) r_buf[c] <= '0;
    end else begin
      if (r_state == FETCH) begin
        for (int c = 0; c < size; c++) r_buf[c] <= row_data[c*ACC_W +: ACC_W];
      end
      if (w_xfer) begin
        if (r_col == c_LAST) begin
          r_col <= '0;
          r_row <= (r_row == c_LAST) ? '0 : r_row + c_ONE;
        end else begin
          r_col <= r_col + c_ONE;
        end
      end
    end
  end

  systolic_sat #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W)
  ) u_sat (
    .i_acc (r_buf[r_col]),
    .o_msg (w_msg)
  );

  assign out_if.out_msg = w_msg;
  assign row_sel        = r_row;
  assign trace_state    = r_state;

endmodule : systolic_drain

`default_nettype wire

// File: tb/tb_systolic_drain.sv
// ============================================================================
// Module   : tb_systolic_drain
// Purpose  : Scoreboard bench for systolic_drain (size=4, ACC_W=32, OUT_W=16).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_systolic_drain;

  localparam int c_SIZE  = 4;
  localparam int c_ACC_W = 32;
  localparam int c_OUT_W = 16;

  logic                      clk;
  logic                      rst_n;
  logic                      start;
  logic [1:0]                row_sel;
  logic [c_SIZE*c_ACC_W-1:0] row_data;
  logic                      acc_clr;
  logic                      busy;
  logic                      done;
  logic [1:0]                trace_state;

  systolic_drain_if #(.OUT_W(c_OUT_W)) dif ();

  systolic_drain #(
    .size  (c_SIZE),
    .ACC_W (c_ACC_W),
    .OUT_W (c_OUT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .row_sel     (row_sel),
    .row_data    (row_data),
    .acc_clr     (acc_clr),
    .busy        (busy),
    .done        (done),
    .trace_state (trace_state),
    .out_if      (dif)
  );

  logic [31:0] acc [c_SIZE][c_SIZE];
  logic [15:0] exp_q [$];
  logic [15:0] obs_q [$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_xfer   = 0;
  int          n_done   = 0;
  int          n_clr    = 0;
  bit          rdy_mode = 1'b0;
  bit          have_hold = 1'b0;
  logic [15:0] hold_msg;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Array model: row_data is combinational from row_sel
  always_comb begin
    row_data = '0;
    for (int c = 0; c < c_SIZE; c++) row_data[c*c_ACC_W +: c_ACC_W] = acc[row_sel][c];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] narrow(input logic [31:0] v);
`ifdef SYSTOLIC_DRAIN_SAT_EN
    int s;
    s = signed'(v);
    if (s > 32767)       return 16'h7FFF;
    else if (s < -32768) return 16'h8000;
    else                 return v[15:0];
`else
    return v[15:0];
`endif
  endfunction

  task automatic load_ramp();
    for (int r = 0; r < c_SIZE; r++)
      for (int c = 0; c < c_SIZE; c++) acc[r][c] = 32'(16*r + c);
  endtask

  task automatic push_expected();
    for (int r = 0; r < c_SIZE; r++)
      for (int c = 0; c < c_SIZE; c++) exp_q.push_back(narrow(acc[r][c]));
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output int first_val);
    bit seen;
    seen = 1'b0; cyc = 0; first_val = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      cyc++;
      if (dif.out_val && first_val == 0) first_val = cyc;
      if (done) begin seen = 1'b1; break; end
    end
    check("done_seen", 32'(seen), 32'd1);
  endtask

  task automatic wait_xfers(input int target);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (n_xfer >= target) begin ok = 1'b1; break; end
    end
    check("xfer_reached", 32'(ok), 32'd1);
  endtask

  initial begin
    dif.out_rdy = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (rdy_mode) dif.out_rdy = ~dif.out_rdy;
      else          dif.out_rdy = 1'b1;
    end
  end

  // Output monitor: scoreboard pop, stall stability, pulse counting
  always @(negedge clk) begin
    if (rst_n) begin
      if (have_hold && dif.out_val) check("stall_hold", 32'(dif.out_msg), 32'(hold_msg));
      have_hold = dif.out_val && !dif.out_rdy;
      hold_msg  = dif.out_msg;
      if (dif.out_val && dif.out_rdy) begin
        if (exp_q.size() == 0) check("sb_underflow", 32'(exp_q.size()), 32'd1);
        else                   check("xfer_data", 32'(dif.out_msg), 32'(exp_q.pop_front()));
        obs_q.push_back(dif.out_msg);
        n_xfer++;
      end
      if (done || acc_clr) check("done_clr_pair", 32'(acc_clr), 32'(done));
      if (done)    n_done++;
      if (acc_clr) n_clr++;
    end else begin
      have_hold = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired n_xfer=%0d", n_xfer);
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, fv, d0, c0, x0;
    logic [15:0] e0, e1;
    rst_n = 1'b0;
    start = 1'b0;
    load_ramp();

    // Reset values and idle behaviour
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_val", 32'(dif.out_val), 32'd0);
    check("rst_out_msg", 32'(dif.out_msg), 32'd0);
    check("rst_row_sel", 32'(row_sel), 32'd0);
    check("rst_state",   32'(trace_state), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_flags", {28'd0, dif.out_val, busy, done, acc_clr}, 32'd0);
      check("idle_state", 32'(trace_state), 32'd0);
    end

    // Ramp drain, out_rdy high
    push_expected();
    d0 = n_done; c0 = n_clr; x0 = n_xfer;
    pulse_start();
    check("fetch_entry", 32'(trace_state), 32'd1);
    check("fetch_no_val", 32'(dif.out_val), 32'd0);
    wait_done(cyc, fv);
    check("first_val_cycle", 32'(fv), 32'd2);
    check("drain_cycles", 32'(cyc), 32'd21);
    check("ramp_xfers", 32'(n_xfer - x0), 32'd16);
    check("ramp_sb_empty", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    check("idle_after", 32'(busy), 32'd0);
    check("done_pulses", 32'(n_done - d0), 32'd1);
    check("clr_pulses",  32'(n_clr - c0), 32'd1);

    // Same drain with out_rdy toggling
    rdy_mode = 1'b1;
    push_expected();
    x0 = n_xfer;
    pulse_start();
    wait_done(cyc, fv);
    check("toggle_xfers", 32'(n_xfer - x0), 32'd16);
    check("toggle_sb_empty", 32'(exp_q.size()), 32'd0);
    rdy_mode = 1'b0;
    repeat (2) @(posedge clk);

    // Narrowing corner values
    acc[0][0] = 32'h0001_2345;
    acc[0][1] = 32'hFFFE_EE90;
`ifdef SYSTOLIC_DRAIN_SAT_EN
    e0 = 16'h7FFF; e1 = 16'h8000;
`else
    e0 = 16'h2345; e1 = 16'hEE90;
`endif
    push_expected();
    obs_q.delete();
    pulse_start();
    wait_done(cyc, fv);
    check("sat_count", 32'(obs_q.size()), 32'd16);
    if (obs_q.size() >= 2) begin
      check("narrow_pos", 32'(obs_q[0]), 32'(e0));
      check("narrow_neg", 32'(obs_q[1]), 32'(e1));
    end
    load_ramp();
    repeat (2) @(posedge clk);

    // Reset after the 5th transfer
    push_expected();
    d0 = n_done; c0 = n_clr; x0 = n_xfer;
    pulse_start();
    wait_xfers(x0 + 5);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_state", 32'(trace_state), 32'd0);
    check("midrst_flags", {28'd0, dif.out_val, busy, done, acc_clr}, 32'd0);
    check("midrst_row", 32'(row_sel), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    exp_q.delete();
    check("midrst_no_done", 32'(n_done - d0), 32'd0);
    check("midrst_no_clr",  32'(n_clr - c0), 32'd0);
    push_expected();
    x0 = n_xfer;
    pulse_start();
    wait_done(cyc, fv);
    check("restart_xfers", 32'(n_xfer - x0), 32'd16);
    check("restart_sb_empty", 32'(exp_q.size()), 32'd0);
    repeat (2) @(posedge clk);

    // start re-pulsed mid-drain is ignored
    push_expected();
    d0 = n_done; x0 = n_xfer;
    pulse_start();
    wait_xfers(x0 + 6);
    pulse_start();
    wait_done(cyc, fv);
    repeat (4) @(negedge clk);
    check("repulse_xfers", 32'(n_xfer - x0), 32'd16);
    check("repulse_sb_empty", 32'(exp_q.size()), 32'd0);
    check("repulse_done", 32'(n_done - d0), 32'd1);
    check("repulse_idle", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_systolic_drain

`default_nettype wire
